// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: shares the single LC3 memory port between instruction fetch
// and the data stage. It sequences direct and indirect (LDI/STI) accesses and
// pulses complete_instr / complete_data when each access finishes.
// Optional feature macro: LC3_ARB_RR_EN. When it is defined, simultaneous
// requests alternate between the two requesters. When it is undefined, data
// always wins a tie.
module lc3_mem_arbiter #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          complete_instr,
  input  logic          d_req,
  input  logic [1:0]    d_mode,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          complete_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    mem_state,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PTR,
    S_DRD,
    S_DWR,
    S_DONE
  } state_t;

  localparam logic [1:0] MS_DRD  = 2'd0;
  localparam logic [1:0] MS_PTR  = 2'd1;
  localparam logic [1:0] MS_DWR  = 2'd2;
  localparam logic [1:0] MS_IDLE = 2'd3;

  localparam logic [1:0] MODE_RD  = 2'd0;
  localparam logic [1:0] MODE_WR  = 2'd2;
  localparam logic [1:0] MODE_IWR = 2'd3;

  state_t     state;
  logic [1:0] mode_q;
  logic       is_data_q;
  logic       grant_data_c;

`ifdef LC3_ARB_RR_EN
  // Remembers which side won the most recent tie (1 = data). Resets to fetch,
  // so the first tie after reset goes to data.
  logic last_data_q;

  // Tie-break: a tie goes to the side that did not win the previous tie.
  always_comb begin
    grant_data_c = d_req && (!if_req || !last_data_q);
  end

  // Update the tie memory only when both sides compete in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_data_q <= 1'b0;
    end else if (state == S_IDLE && if_req && d_req) begin
      last_data_q <= grant_data_c;
    end
  end
`else
  // Fixed priority: data always wins over fetch.
  always_comb begin
    grant_data_c = d_req;
  end
`endif

  // Main sequencer: grant, memory handshake, result capture and done pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      mode_q         <= 2'd0;
      is_data_q      <= 1'b0;
      if_rdata       <= '0;
      d_rdata        <= '0;
      complete_instr <= 1'b0;
      complete_data  <= 1'b0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_state      <= MS_IDLE;
      busy           <= 1'b0;
    end else begin
      complete_instr <= 1'b0;
      complete_data  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_data_c) begin
            is_data_q <= 1'b1;
            mode_q    <= d_mode;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_req   <= 1'b1;
            busy      <= 1'b1;
            case (d_mode)
              MODE_RD: begin
                state     <= S_DRD;
                mem_we    <= 1'b0;
                mem_state <= MS_DRD;
              end
              MODE_WR: begin
                state     <= S_DWR;
                mem_we    <= 1'b1;
                mem_state <= MS_DWR;
              end
              default: begin
                state     <= S_PTR;
                mem_we    <= 1'b0;
                mem_state <= MS_PTR;
              end
            endcase
          end else if (if_req) begin
            is_data_q <= 1'b0;
            mem_addr  <= if_addr;
            mem_we    <= 1'b0;
            mem_req   <= 1'b1;
            busy      <= 1'b1;
            state     <= S_FETCH;
            mem_state <= MS_IDLE;
          end
        end

        S_FETCH: begin
          if (mem_ack) begin
            if_rdata       <= mem_rdata;
            complete_instr <= 1'b1;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_state      <= MS_IDLE;
            state          <= S_DONE;
          end
        end

        // The pointer replaces the address. The data phase follows with no gap.
        S_PTR: begin
          if (mem_ack) begin
            mem_addr <= AW'(mem_rdata);
            if (mode_q == MODE_IWR) begin
              state     <= S_DWR;
              mem_we    <= 1'b1;
              mem_state <= MS_DWR;
            end else begin
              state     <= S_DRD;
              mem_we    <= 1'b0;
              mem_state <= MS_DRD;
            end
          end
        end

        S_DRD: begin
          if (mem_ack) begin
            d_rdata       <= mem_rdata;
            complete_data <= is_data_q;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_state     <= MS_IDLE;
            state         <= S_DONE;
          end
        end

        S_DWR: begin
          if (mem_ack) begin
            complete_data <= is_data_q;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_state     <= MS_IDLE;
            state         <= S_DONE;
          end
        end

        S_DONE: begin
          busy      <= 1'b0;
          mem_state <= MS_IDLE;
          state     <= S_IDLE;
        end

        default: begin
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          busy      <= 1'b0;
          mem_state <= MS_IDLE;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Testbench for lc3_mem_arbiter. A scoreboard records the expected
// instruction results, data results and memory writes when each request is
// issued. A monitor and a memory responder compare against those records as
// the DUT produces them. The bench defines LC3_ARB_RR_EN to match the DUT
// build.
module tb_lc3_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        complete_instr;
  logic        d_req;
  logic [1:0]  d_mode;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        complete_data;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [1:0]  mem_state;
  logic        busy;

  lc3_mem_arbiter #(.AW(16), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .complete_instr(complete_instr),
    .d_req(d_req), .d_mode(d_mode), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .complete_data(complete_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_state(mem_state), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wait_cfg = 0;   // negative: random 0..3 wait cycles per access
  bit spur_en = 1'b1; // stray acks while mem_req is low
  int ci_count = 0;
  int cd_count = 0;

  logic [15:0] bus_mem   [logic [15:0]];
  logic [15:0] model_mem [logic [15:0]];
  logic [15:0] exp_i [$];
  logic [15:0] exp_d [$];
  logic [31:0] exp_wr [$];
  int          done_order [$];
  logic [19:0] trace [$];
  bit          trace_en = 1'b0;
  logic [15:0] last_rd = 16'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Initial memory image. The pointer table at 0x4xxx points into 0x500x.
  // No access ever writes the table or the fetch region.
  function automatic logic [15:0] init_val(input logic [15:0] a);
    if (a[15:12] == 4'h4) return 16'h5000 | {12'h0, a[3:0]};
    return a ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [15:0] bus_rd(input logic [15:0] a);
    if (bus_mem.exists(a)) return bus_mem[a];
    return init_val(a);
  endfunction

  task automatic poke(input logic [15:0] a, input logic [15:0] v);
    bus_mem[a]   = v;
    model_mem[a] = v;
  endtask

  // Memory responder: applies wait states, checks that the request is stable
  // while waiting, and checks every write against the scoreboard.
  initial begin
    bit          new_acc;
    int          wl;
    logic [32:0] snap;
    new_acc   = 1'b1;
    wl        = 0;
    snap      = '0;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (rst || !mem_req) begin
        new_acc   = 1'b1;
        mem_ack   = spur_en && ($urandom_range(0, 3) == 0);
        mem_rdata = 16'($urandom);
      end else begin
        if (new_acc) begin
          new_acc = 1'b0;
          wl      = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
          snap    = {mem_we, mem_addr, mem_wdata};
        end else begin
          check("req_stable", 32'({mem_we, mem_addr, mem_wdata} == snap), 32'd1);
        end
        if (wl == 0) begin
          mem_ack = 1'b1;
          new_acc = 1'b1;
          if (mem_we) begin
            bus_mem[mem_addr] = mem_wdata;
            mem_rdata = 16'($urandom);
            if (exp_wr.size() == 0) begin
              n_cmp++; n_bad++;
              $display("FAIL unexpected_write: got %h<=%h expected none", mem_addr, mem_wdata);
            end else begin
              check("mem_write", {mem_addr, mem_wdata}, exp_wr.pop_front());
            end
          end else begin
            mem_rdata = bus_rd(mem_addr);
          end
        end else begin
          wl--;
          mem_ack   = 1'b0;
          mem_rdata = 16'($urandom);
        end
      end
    end
  end

  // Monitor: pops the expected result whenever a completion pulse appears.
  always @(negedge clk) begin
    if (trace_en) trace.push_back({mem_req, mem_we, mem_state, mem_addr});
    if (complete_instr) begin
      ci_count++;
      done_order.push_back(0);
      if (exp_i.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_complete_instr: got pulse expected none");
      end else check("if_rdata", 32'(if_rdata), 32'(exp_i.pop_front()));
    end
    if (complete_data) begin
      cd_count++;
      done_order.push_back(1);
      if (exp_d.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_complete_data: got pulse expected none");
      end else check("d_rdata", 32'(d_rdata), 32'(exp_d.pop_front()));
    end
  end

  // Fetch requester: holds if_req until complete_instr, then drops it.
  task automatic do_fetch(input logic [15:0] a, input bit scr, output int lat);
    bit done;
    int g;
    exp_i.push_back(model_rd(a));
    if_addr = a;
    if_req  = 1'b1;
    g = cyc; done = 1'b0; lat = -1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (complete_instr) begin
        done = 1'b1;
        lat  = cyc - g;
      end else if (scr) begin
        @(posedge clk); #1;
        if_addr = 16'($urandom);
      end
    end
    check("fetch_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    if_req  = 1'b0;
    if_addr = 16'($urandom);
  endtask

  // Data requester: predicts the result and memory effect, then performs the
  // handshake.
  task automatic do_data(input logic [1:0] m, input logic [15:0] a, input logic [15:0] w,
                         input bit scr, output int lat);
    bit          done;
    int          g;
    logic [15:0] p;
    logic [15:0] e;
    case (m)
      2'd0: begin e = model_rd(a); last_rd = e; end
      2'd1: begin p = model_rd(a); e = model_rd(p); last_rd = e; end
      2'd2: begin model_mem[a] = w; exp_wr.push_back({a, w}); e = last_rd; end
      default: begin p = model_rd(a); model_mem[p] = w; exp_wr.push_back({p, w}); e = last_rd; end
    endcase
    exp_d.push_back(e);
    d_mode = m; d_addr = a; d_wdata = w; d_req = 1'b1;
    g = cyc; done = 1'b0; lat = -1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (complete_data) begin
        done = 1'b1;
        lat  = cyc - g;
      end else if (scr) begin
        @(posedge clk); #1;
        d_mode = 2'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
      end
    end
    check("data_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2, cd0;
    rst = 1'b1; if_req = 1'b0; if_addr = 16'h0;
    d_req = 1'b0; d_mode = 2'd0; d_addr = 16'h0; d_wdata = 16'h0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 32'({mem_req, mem_we}), 32'd0);
    check("rst_mem_addr", 32'({mem_addr, mem_wdata}), 32'd0);
    check("rst_rdata", 32'({if_rdata, d_rdata}), 32'd0);
    check("rst_complete", 32'({complete_instr, complete_data}), 32'd0);
    check("rst_mem_state", 32'(mem_state), 32'd3);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Zero-wait fetch
    wait_cfg = 0;
    poke(16'h3000, 16'h1234);
    trace.delete(); trace_en = 1'b1;
    do_fetch(16'h3000, 1'b1, lat);
    trace_en = 1'b0;
    check("fetch_g1_bus", 32'(trace[1]), 32'({1'b1, 1'b0, 2'd3, 16'h3000}));
    check("fetch_latency", 32'(lat), 32'd2);

    // LDI zero-wait
    poke(16'h4000, 16'h5000);
    poke(16'h5000, 16'hBEEF);
    trace.delete(); trace_en = 1'b1;
    do_data(2'd1, 16'h4000, 16'h0, 1'b1, lat);
    trace_en = 1'b0;
    check("ldi_ptr_phase", 32'(trace[1]), 32'({1'b1, 1'b0, 2'd1, 16'h4000}));
    check("ldi_data_phase", 32'(trace[2]), 32'({1'b1, 1'b0, 2'd0, 16'h5000}));
    check("ldi_latency", 32'(lat), 32'd3);

    // STI with two wait cycles per access; d_rdata must keep 0xBEEF
    wait_cfg = 2;
    cd0 = cd_count;
    trace.delete(); trace_en = 1'b1;
    do_data(2'd3, 16'h4000, 16'h00AA, 1'b1, lat);
    repeat (3) @(posedge clk);
    #1;
    trace_en = 1'b0;
    check("sti_ptr_held", 32'(trace[3]), 32'({1'b1, 1'b0, 2'd1, 16'h4000}));
    check("sti_write_phase", 32'(trace[4]), 32'({1'b1, 1'b1, 2'd2, 16'h5000}));
    check("sti_latency", 32'(lat), 32'd7);
    check("sti_one_complete", 32'(cd_count - cd0), 32'd1);
    check("sti_write_seen", 32'(exp_wr.size()), 32'd0);

    // Two consecutive ties
    wait_cfg = -1;
    done_order.delete();
    fork
      do_fetch(16'h3010, 1'b0, lat);
      do_data(2'd0, 16'h5001, 16'h0, 1'b0, lat2);
    join
    check("tie1_winner", 32'(done_order[0]), 32'd1);
    done_order.delete();
    fork
      do_fetch(16'h3020, 1'b0, lat);
      do_data(2'd0, 16'h5002, 16'h0, 1'b0, lat2);
    join
`ifdef LC3_ARB_RR_EN
    check("tie2_winner", 32'(done_order[0]), 32'd0);
`else
    check("tie2_winner", 32'(done_order[0]), 32'd1);
`endif

    // Reset during the pointer phase of an LDI
    wait_cfg = 3;
    cd0 = cd_count;
    d_mode = 2'd1; d_addr = 16'h4003; d_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_in_ptr", 32'(mem_state), 32'd1);
    rst = 1'b1; d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_mem_state", 32'(mem_state), 32'd3);
    check("abort_d_rdata", 32'(d_rdata), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (6) @(negedge clk);
    check("abort_no_complete", 32'(cd_count - cd0), 32'd0);
    last_rd = 16'h0;
    @(posedge clk); #1;

    // Randomized concurrent traffic
    wait_cfg = -1;
    fork
      begin
        int l;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          do_fetch(16'h3000 + 16'($urandom_range(0, 255)), 1'b0, l);
        end
      end
      begin
        int l;
        logic [1:0] m;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          m = 2'($urandom);
          do_data(m, (m[0] ? 16'h4000 : 16'h5000) + 16'($urandom_range(0, 15)),
                  16'($urandom), 1'b0, l);
        end
      end
    join
    repeat (4) @(posedge clk);
    check("sb_instr_empty", 32'(exp_i.size()), 32'd0);
    check("sb_data_empty", 32'(exp_d.size()), 32'd0);
    check("sb_write_empty", 32'(exp_wr.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lc3_mem_arbiter.md
# lc3_mem_arbiter

Sequences and shares the single LC3 unified memory port between the instruction-fetch requester and the data (memory-access stage) requester. Handles direct loads and stores and the two-phase indirect accesses (LDI/STI) internally. Reports progress on `mem_state`, and raises the `complete_instr` / `complete_data` pulses that the pipeline controller uses to release its stage enables.

## Interface
- `AW`, default 16: address width.
- `DW`, default 16: data width.

Reset is `rst`, synchronous, active-high; the clock is `clk`.

- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `if_req`  in  1  fetch request, level, held until `complete_instr`
- `if_addr`  in  AW  fetch address (PC)
- `if_rdata`  out  DW  fetched instruction, valid from `complete_instr`, held
- `complete_instr`  out  1  one-cycle fetch-done pulse
- `d_req`  in  1  data request, level, held until `complete_data`
- `d_mode`  in  2  0 = direct read, 1 = indirect read, 2 = direct write, 3 = indirect write
- `d_addr`  in  AW  data address (or pointer address if indirect)
- `d_wdata`  in  DW  store data
- `d_rdata`  out  DW  load result, valid from `complete_data`, held
- `complete_data`  out  1  one-cycle data-done pulse (reads and writes)
- `mem_req`  out  1  memory request
- `mem_we`  out  1  write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_ack`  in  1  access done this cycle; `mem_rdata` is valid when high
- `mem_rdata`  in  DW  memory read data
- `mem_state`  out  2  0 = data read, 1 = pointer read, 2 = data write, 3 = idle/fetch
- `busy`  out  1  high in every state except IDLE

## Operation
- States:
  - IDLE
  - FETCH
  - PTR (pointer read)
  - DRD (data read)
  - DWR (data write)
  - DONE
- Grant happens only in IDLE:
  - `d_req` alone → data path.
  - `if_req` alone → FETCH.
  - Both → see Configuration.
- At grant, the block captures the address, `d_mode` and `d_wdata`. Request inputs are ignored while `busy`.
- Data path entry state by `d_mode`:
  - Mode 0 → DRD.
  - Mode 2 → DWR.
  - Modes 1 and 3 → PTR.
- In PTR, on `mem_ack`, `mem_rdata` replaces the captured address. The next state is DRD (mode 1) or DWR (mode 3).
- `mem_req` is high in FETCH, PTR, DRD and DWR. `mem_we` is high only in DWR.
- `mem_addr`, `mem_we` and `mem_wdata` stay stable until `mem_ack`. Any number of wait cycles is allowed.
- On `mem_ack` in FETCH, DRD or DWR:
  - Read data is captured into `if_rdata` or `d_rdata`.
  - The FSM moves to DONE.
- DONE pulses the matching complete output for exactly one cycle, then returns to IDLE.
- `mem_ack` while `mem_req` is low is ignored.
- A write leaves `d_rdata` unchanged. The pointer value is never exposed on `d_rdata`.
- `mem_state` is registered from the FSM state:
  - PTR = 1
  - DRD = 0
  - DWR = 2
  - all other states = 3

## Timing
- Reset values:
  - all outputs 0, except `mem_state` = 3
  - FSM in IDLE
  - `if_rdata` and `d_rdata` = 0
- Grant cycle is G (IDLE). `mem_req` is first high in cycle G+1.
- With a zero-wait memory (ack in the same cycle as req):
  - Fetch and direct access: complete pulse in cycle G+2.
  - Indirect access: complete pulse in cycle G+3.
  - Each wait cycle adds 1.
- Requester handshake: the requester sees complete at the end of the DONE cycle and drops `req` the following cycle. IDLE samples in that cycle, so no spurious re-grant occurs.
- Back-to-back minimum: a new grant can occur in the cycle after DONE. The throughput floor is one access per 3 cycles.
- Reset asserted mid-access:
  - Next cycle: `mem_req` = 0, FSM = IDLE, `mem_state` = 3.
  - No complete pulse is produced.
  - The access in flight is abandoned.

## Configuration
- `LC3_ARB_RR_EN` undefined: on simultaneous `if_req` and `d_req` in IDLE, data always wins. Fetch waits until data reaches DONE.
- `LC3_ARB_RR_EN` defined:
  - Simultaneous requests alternate, granting the requester not granted last.
  - A last-grant register resets to "fetch", so the first tie goes to data.
  - Single requests are unaffected.

## Test plan
- Reset: hold `rst` for 2 cycles → every output 0, `mem_state` = 3, `busy` = 0.
- Fetch, zero-wait memory: `if_req` with `if_addr` = 0x3000, memory returns 0x1234 → `mem_req` high with `mem_addr` = 0x3000 and `mem_we` = 0 in G+1; `complete_instr` in G+2; `if_rdata` = 0x1234.
- LDI: `d_mode` = 1, `d_addr` = 0x4000, mem[0x4000] = 0x5000, mem[0x5000] = 0xBEEF → `mem_state` goes 1 then 0; `complete_data` in G+3; `d_rdata` = 0xBEEF.
- STI with 2 wait cycles per access: `d_mode` = 3, `d_addr` = 0x4000, `d_wdata` = 0x00AA → pointer read is held stable for 3 cycles; then a write of 0x00AA to 0x5000 with `mem_we` = 1 and `mem_state` = 2; exactly one `complete_data`.
- Simultaneous `if_req` and `d_req`, repeated twice → data granted first.
  - Without the macro: data granted again on the second tie.
  - With `LC3_ARB_RR_EN`: fetch granted on the second tie.
- Reset during PTR of an LDI → `mem_req` = 0 in the next cycle, no `complete_data`, `d_rdata` = 0, `mem_state` = 3.
